// File: rtl/aurora_init_pkg.sv
// Shared types and default parameter values for the Aurora channel init sequencer.
package aurora_init_pkg;

  typedef enum logic [1:0] {
    StHold   = 2'd0,
    StRelGt  = 2'd1,
    StWaitUp = 2'd2,
    StUp     = 2'd3
  } ch_state_e;

  localparam int unsigned DefNumCh        = 2;
  localparam int unsigned DefRstHoldCyc   = 14;
  localparam int unsigned DefAuroraRstLag = 4;
  localparam int unsigned DefStableCyc    = 8;
  localparam int unsigned DefTimeoutCyc   = 4096;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aurora_init_ch.sv
// One Aurora channel: channel_up synchroniser, reset-release FSM and counters.
// Optional WAIT_UP watchdog enabled by AURORA_INIT_WATCHDOG_EN.
module aurora_init_ch
  import aurora_init_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYC   = DefRstHoldCyc,
  parameter int unsigned AURORA_RST_LAG = DefAuroraRstLag,
  parameter int unsigned STABLE_CYC     = DefStableCyc,
  parameter int unsigned TIMEOUT_CYC    = DefTimeoutCyc
) (
  input  logic       init_clk,
  input  logic       RST,
  input  logic       channel_up,
  input  logic       reinit,
  output logic       gt_reset,
  output logic       reset_aurora,
  output logic       reset_txrx,
  output logic       is_up,
  output logic [7:0] retry_cnt
);

`ifdef AURORA_INIT_WATCHDOG_EN
  localparam int unsigned CntMax = max_u(max_u(RST_HOLD_CYC, AURORA_RST_LAG), TIMEOUT_CYC);
`else
  localparam int unsigned CntMax = max_u(RST_HOLD_CYC, AURORA_RST_LAG);
`endif
  localparam int unsigned CntW  = $clog2(CntMax + 1);
  localparam int unsigned StabW = $clog2(STABLE_CYC + 1);

  logic            sync1_q = 1'b0;
  logic            sync2_q = 1'b0;
  ch_state_e       state_q = StHold;
  ch_state_e       state_d;
  logic [CntW-1:0]  cnt_q = '0;
  logic [CntW-1:0]  cnt_d;
  logic [StabW-1:0] stab_q = '0;
  logic [StabW-1:0] stab_d;
  logic            wd_expire;

  always_ff @(posedge init_clk) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= StHold;
      cnt_q   <= '0;
      stab_q  <= '0;
    end else begin
      sync1_q <= channel_up;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stab_d    = '0;
    wd_expire = 1'b0;
    unique case (state_q)
      StHold: begin
        if (cnt_q == CntW'(RST_HOLD_CYC - 1)) state_d = StRelGt;
        else cnt_d = cnt_q + CntW'(1);
      end
      StRelGt: begin
        if (cnt_q == CntW'(AURORA_RST_LAG - 1)) state_d = StWaitUp;
        else cnt_d = cnt_q + CntW'(1);
      end
      StWaitUp: begin
        // A low sample leaves stab_d at its default of zero.
        if (sync2_q) begin
          if (stab_q == StabW'(STABLE_CYC - 1)) state_d = StUp;
          else stab_d = stab_q + StabW'(1);
        end
`ifdef AURORA_INIT_WATCHDOG_EN
        if (state_d == StWaitUp) begin
          if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
            state_d   = StHold;
            wd_expire = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
`endif
      end
      StUp: begin
        if (!sync2_q) state_d = StWaitUp;
      end
      default: state_d = StHold;
    endcase

    if (reinit) begin
      state_d   = StHold;
      wd_expire = 1'b0;
    end
    if (reinit || (state_d != state_q)) begin
      cnt_d  = '0;
      stab_d = '0;
    end
  end

  assign gt_reset     = (state_q == StHold);
  assign reset_aurora = (state_q == StHold) || (state_q == StRelGt);
  assign reset_txrx   = (state_q != StUp);
  assign is_up        = (state_q == StUp);

`ifdef AURORA_INIT_WATCHDOG_EN
  logic [7:0] retry_q = '0;

  always_ff @(posedge init_clk) begin
    if (RST) begin
      retry_q <= '0;
    end else if (wd_expire && (retry_q != 8'hFF)) begin
      retry_q <= retry_q + 8'd1;
    end
  end

  assign retry_cnt = retry_q;
`else
  logic unused_wd;
  assign unused_wd = wd_expire ^ (^TIMEOUT_CYC);
  assign retry_cnt = '0;
`endif

endmodule

// File: rtl/aurora_init_seq.sv
// Multi-channel Aurora init sequencer: one aurora_init_ch per channel plus link_ok.
// Watchdog retries enabled by defining AURORA_INIT_WATCHDOG_EN.
module aurora_init_seq
  import aurora_init_pkg::*;
#(
  parameter int unsigned NUM_CH         = DefNumCh,
  parameter int unsigned RST_HOLD_CYC   = DefRstHoldCyc,
  parameter int unsigned AURORA_RST_LAG = DefAuroraRstLag,
  parameter int unsigned STABLE_CYC     = DefStableCyc,
  parameter int unsigned TIMEOUT_CYC    = DefTimeoutCyc
) (
  input  logic                  init_clk,
  input  logic                  RST,
  input  logic [NUM_CH-1:0]     channel_up,
  input  logic [NUM_CH-1:0]     reinit,
  output logic [NUM_CH-1:0]     gt_reset,
  output logic [NUM_CH-1:0]     reset_aurora,
  output logic [NUM_CH-1:0]     reset_txrx,
  output logic                  link_ok,
  output logic [8*NUM_CH-1:0]   retry_cnt
);

  logic [NUM_CH-1:0] ch_up;
  logic              link_ok_q = 1'b0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    aurora_init_ch #(
      .RST_HOLD_CYC   (RST_HOLD_CYC),
      .AURORA_RST_LAG (AURORA_RST_LAG),
      .STABLE_CYC     (STABLE_CYC),
      .TIMEOUT_CYC    (TIMEOUT_CYC)
    ) u_ch (
      .init_clk     (init_clk),
      .RST          (RST),
      .channel_up   (channel_up[i]),
      .reinit       (reinit[i]),
      .gt_reset     (gt_reset[i]),
      .reset_aurora (reset_aurora[i]),
      .reset_txrx   (reset_txrx[i]),
      .is_up        (ch_up[i]),
      .retry_cnt    (retry_cnt[8*i +: 8])
    );
  end

  always_ff @(posedge init_clk) begin
    if (RST) link_ok_q <= 1'b0;
    else     link_ok_q <= &ch_up;
  end

  assign link_ok = link_ok_q;

endmodule

// File: tb/tb_aurora_init_seq.sv
// Directed self-checking bench for aurora_init_seq (NUM_CH=2, TIMEOUT_CYC=64).
module tb_aurora_init_seq;

  logic        init_clk = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  channel_up = 2'b00;
  logic [1:0]  reinit = 2'b00;
  logic [1:0]  gt_reset;
  logic [1:0]  reset_aurora;
  logic [1:0]  reset_txrx;
  logic        link_ok;
  logic [15:0] retry_cnt;

  int n_chk = 0;
  int n_fail = 0;

  aurora_init_seq #(
    .NUM_CH         (2),
    .RST_HOLD_CYC   (14),
    .AURORA_RST_LAG (4),
    .STABLE_CYC     (8),
    .TIMEOUT_CYC    (64)
  ) dut (
    .init_clk     (init_clk),
    .RST          (RST),
    .channel_up   (channel_up),
    .reinit       (reinit),
    .gt_reset     (gt_reset),
    .reset_aurora (reset_aurora),
    .reset_txrx   (reset_txrx),
    .link_ok      (link_ok),
    .retry_cnt    (retry_cnt)
  );

  always #5 init_clk = ~init_clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge init_clk);
    #1;
  endtask

  task automatic release_rst();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; channel_up = 2'b11; reinit = 2'b00;
    tick(3);
    n_chk++; if (gt_reset !== 2'b11) begin n_fail++; $display("FAIL reset_gt: got %b want 11", gt_reset); end
    n_chk++; if (reset_aurora !== 2'b11) begin n_fail++; $display("FAIL reset_ra: got %b want 11", reset_aurora); end
    n_chk++; if (reset_txrx !== 2'b11) begin n_fail++; $display("FAIL reset_tx: got %b want 11", reset_txrx); end
    n_chk++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL reset_link: got %b want 0", link_ok); end
    n_chk++; if (retry_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_retry: got %h want 0000", retry_cnt); end
  endtask

  task automatic test_bringup();
    channel_up = 2'b11;
    release_rst();
    tick(13);
    n_chk++; if (gt_reset !== 2'b11) begin n_fail++; $display("FAIL bringup_gt_hold: got %b want 11", gt_reset); end
    tick(1);
    n_chk++; if (gt_reset !== 2'b00) begin n_fail++; $display("FAIL bringup_gt_fall: got %b want 00", gt_reset); end
    tick(3);
    n_chk++; if (reset_aurora !== 2'b11) begin n_fail++; $display("FAIL bringup_ra_hold: got %b want 11", reset_aurora); end
    tick(1);
    n_chk++; if (reset_aurora !== 2'b00) begin n_fail++; $display("FAIL bringup_ra_fall: got %b want 00", reset_aurora); end
    tick(7);
    n_chk++; if (reset_txrx !== 2'b11) begin n_fail++; $display("FAIL bringup_tx_hold: got %b want 11", reset_txrx); end
    tick(1);
    n_chk++; if (reset_txrx !== 2'b00) begin n_fail++; $display("FAIL bringup_tx_fall: got %b want 00", reset_txrx); end
    n_chk++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL bringup_link_lat: got %b want 0", link_ok); end
    tick(1);
    n_chk++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL bringup_link_rise: got %b want 1", link_ok); end
  endtask

  task automatic test_glitch();
    channel_up = 2'b10;
    release_rst();
    tick(18);
    n_chk++; if ({gt_reset[0], reset_aurora[0], reset_txrx[0]} !== 3'b001) begin
      n_fail++; $display("FAIL glitch_waitup: got %b want 001", {gt_reset[0], reset_aurora[0], reset_txrx[0]});
    end
    channel_up = 2'b11;
    tick(5);
    channel_up = 2'b10;
    tick(1);
    channel_up = 2'b11;
    tick(1);
    n_chk++; if (reset_txrx[0] !== 1'b1) begin n_fail++; $display("FAIL glitch_short_run: got %b want 1", reset_txrx[0]); end
    tick(8);
    n_chk++; if (reset_txrx[0] !== 1'b1) begin n_fail++; $display("FAIL glitch_seven: got %b want 1", reset_txrx[0]); end
    tick(1);
    n_chk++; if (reset_txrx[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_eight: got %b want 0", reset_txrx[0]); end
    tick(1);
    n_chk++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL glitch_link: got %b want 1", link_ok); end
  endtask

  task automatic test_drop();
    channel_up = 2'b01;
    tick(1);
    channel_up = 2'b11;
    tick(1);
    n_chk++; if (reset_txrx[1] !== 1'b0) begin n_fail++; $display("FAIL drop_sync_lat: got %b want 0", reset_txrx[1]); end
    tick(1);
    n_chk++; if (reset_txrx !== 2'b10) begin n_fail++; $display("FAIL drop_tx: got %b want 10", reset_txrx); end
    n_chk++; if (reset_aurora[1] !== 1'b0) begin n_fail++; $display("FAIL drop_ra: got %b want 0", reset_aurora[1]); end
    tick(1);
    n_chk++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL drop_link: got %b want 0", link_ok); end
    n_chk++; if (reset_txrx[0] !== 1'b0) begin n_fail++; $display("FAIL drop_ch0: got %b want 0", reset_txrx[0]); end
    tick(6);
    n_chk++; if (reset_txrx[1] !== 1'b1) begin n_fail++; $display("FAIL drop_restable: got %b want 1", reset_txrx[1]); end
    tick(1);
    n_chk++; if (reset_txrx[1] !== 1'b0) begin n_fail++; $display("FAIL drop_recover: got %b want 0", reset_txrx[1]); end
    tick(1);
    n_chk++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL drop_link_back: got %b want 1", link_ok); end
  endtask

  task automatic test_reinit();
    reinit = 2'b01;
    tick(1);
    reinit = 2'b00;
    n_chk++; if (gt_reset !== 2'b01) begin n_fail++; $display("FAIL reinit_gt: got %b want 01", gt_reset); end
    n_chk++; if (reset_txrx !== 2'b01) begin n_fail++; $display("FAIL reinit_tx: got %b want 01", reset_txrx); end
    tick(1);
    n_chk++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL reinit_link: got %b want 0", link_ok); end
    tick(12);
    n_chk++; if (gt_reset[0] !== 1'b1) begin n_fail++; $display("FAIL reinit_hold: got %b want 1", gt_reset[0]); end
    tick(1);
    n_chk++; if (gt_reset[0] !== 1'b0) begin n_fail++; $display("FAIL reinit_gt_fall: got %b want 0", gt_reset[0]); end
    tick(3);
    n_chk++; if (reset_aurora[0] !== 1'b1) begin n_fail++; $display("FAIL reinit_ra_hold: got %b want 1", reset_aurora[0]); end
    tick(1);
    n_chk++; if (reset_aurora[0] !== 1'b0) begin n_fail++; $display("FAIL reinit_ra_fall: got %b want 0", reset_aurora[0]); end
    tick(7);
    n_chk++; if (reset_txrx !== 2'b01) begin n_fail++; $display("FAIL reinit_tx_hold: got %b want 01", reset_txrx); end
    tick(1);
    n_chk++; if (reset_txrx !== 2'b00) begin n_fail++; $display("FAIL reinit_tx_fall: got %b want 00", reset_txrx); end
    tick(1);
    n_chk++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL reinit_link_back: got %b want 1", link_ok); end
  endtask

  task automatic test_rst_mid();
    channel_up = 2'b11;
    release_rst();
    tick(15);
    n_chk++; if ({gt_reset, reset_aurora} !== 4'b0011) begin
      n_fail++; $display("FAIL rstmid_relgt: got %b want 0011", {gt_reset, reset_aurora});
    end
    RST = 1'b1;
    tick(1);
    n_chk++; if ({gt_reset, reset_aurora, reset_txrx} !== 6'b111111) begin
      n_fail++; $display("FAIL rstmid_outs: got %b want 111111", {gt_reset, reset_aurora, reset_txrx});
    end
    n_chk++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL rstmid_link: got %b want 0", link_ok); end
    RST = 1'b0;
    tick(13);
    n_chk++; if (gt_reset !== 2'b11) begin n_fail++; $display("FAIL rstmid_rehold: got %b want 11", gt_reset); end
    tick(1);
    n_chk++; if (gt_reset !== 2'b00) begin n_fail++; $display("FAIL rstmid_gt_fall: got %b want 00", gt_reset); end
  endtask

  task automatic test_watchdog();
    channel_up = 2'b10;
    release_rst();
    tick(18);
    n_chk++; if ({gt_reset[0], reset_aurora[0], reset_txrx[0]} !== 3'b001) begin
      n_fail++; $display("FAIL wd_waitup: got %b want 001", {gt_reset[0], reset_aurora[0], reset_txrx[0]});
    end
`ifdef AURORA_INIT_WATCHDOG_EN
    tick(63);
    n_chk++; if (gt_reset[0] !== 1'b0) begin n_fail++; $display("FAIL wd_early: got %b want 0", gt_reset[0]); end
    tick(1);
    n_chk++; if (gt_reset[0] !== 1'b1) begin n_fail++; $display("FAIL wd_timeout: got %b want 1", gt_reset[0]); end
    n_chk++; if (retry_cnt[7:0] !== 8'd1) begin n_fail++; $display("FAIL wd_retry1: got %0d want 1", retry_cnt[7:0]); end
    tick(82);
    n_chk++; if (retry_cnt[7:0] !== 8'd2) begin n_fail++; $display("FAIL wd_retry2: got %0d want 2", retry_cnt[7:0]); end
    tick(82 * 260);
    n_chk++; if (retry_cnt[7:0] !== 8'd255) begin n_fail++; $display("FAIL wd_sat: got %0d want 255", retry_cnt[7:0]); end
    n_chk++; if (retry_cnt[15:8] !== 8'd0) begin n_fail++; $display("FAIL wd_ch1: got %0d want 0", retry_cnt[15:8]); end
`else
    tick(300);
    n_chk++; if ({gt_reset[0], reset_aurora[0], reset_txrx[0]} !== 3'b001) begin
      n_fail++; $display("FAIL wd_stays: got %b want 001", {gt_reset[0], reset_aurora[0], reset_txrx[0]});
    end
    n_chk++; if (retry_cnt !== 16'h0) begin n_fail++; $display("FAIL wd_noretry: got %h want 0000", retry_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_drop();
    test_reinit();
    test_rst_mid();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
